// File: rtl/vrf_read_pkg.sv
// Shared types and constants for the VRF read responder and its response FIFO.
package vrf_read_pkg;

    localparam int VS_W       = 5;
    localparam int OFFSET_W   = 6;
    localparam int VRF_ADDR_W = 11;
    localparam int RS_W       = 2;
    localparam int II_W       = 3;

    typedef struct packed {
        logic [VS_W-1:0]     vs;
        logic [RS_W-1:0]     readSource;
        logic [OFFSET_W-1:0] offset;
        logic [II_W-1:0]     instructionIndex;
    } vrf_read_req_t;

    typedef struct packed {
        logic [RS_W-1:0] readSource;
        logic [II_W-1:0] instructionIndex;
    } vrf_read_tag_t;

    function automatic logic [VRF_ADDR_W-1:0] vrf_addr(input vrf_read_req_t r);
        return {r.vs, r.offset};
    endfunction

endpackage

// File: rtl/vrf_read_responder_if.sv
// Request/response handshake bundle between the read arbiter (master) and the responder (slave).
interface vrf_read_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_bits_vs;
    logic [1:0]            req_bits_readSource;
    logic [5:0]            req_bits_offset;
    logic [2:0]            req_bits_instructionIndex;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_bits_data;
    logic [1:0]            resp_bits_readSource;
    logic [2:0]            resp_bits_instructionIndex;

    modport master (
        output req_valid, req_bits_vs, req_bits_readSource, req_bits_offset,
               req_bits_instructionIndex, resp_ready,
        input  req_ready, resp_valid, resp_bits_data, resp_bits_readSource,
               resp_bits_instructionIndex
    );

    modport slave (
        input  req_valid, req_bits_vs, req_bits_readSource, req_bits_offset,
               req_bits_instructionIndex, resp_ready,
        output req_ready, resp_valid, resp_bits_data, resp_bits_readSource,
               resp_bits_instructionIndex
    );
endinterface

// File: rtl/vrf_resp_fifo.sv
// In-order response FIFO: circular buffer of {data, tag} with read/write pointers and an occupancy count.
module vrf_resp_fifo
    import vrf_read_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 4,
    parameter type T_TAG      = vrf_read_tag_t,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  T_TAG                  i_push_tag,
    input  logic                  i_pop,
    output logic [CNT_W-1:0]      o_count,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output T_TAG                  o_head_tag
);
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    T_TAG                  r_mem_tag  [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    // Storage carries no reset: contents are only observed when count says they are live.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem_data[r_wptr] <= i_push_data;
            r_mem_tag[r_wptr]  <= i_push_tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (!(i_push && !i_pop && r_count == CNT_W'(DEPTH)));
            assert (!(i_pop && r_count == '0));
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_mem_data[r_rptr];
    assign o_head_tag  = r_mem_tag[r_rptr];
endmodule

// File: rtl/vrf_read_responder.sv
// Responder end of the VRF read handshake: credit-gated SRAM issue, tag pipeline, in-order response FIFO.
// Optional perf counters are built when VRF_READ_RESPONDER_PERF_EN is defined.
module vrf_read_responder
    import vrf_read_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    vrf_read_responder_if.slave   rd,
    output logic                  sram_ren,
    output logic [VRF_ADDR_W-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  idle
`ifdef VRF_READ_RESPONDER_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_reads
`endif
);
    localparam int CW = $clog2(RESP_DEPTH) + 1;

    logic [CW-1:0]         r_credit;
    logic                  w_req_ready;
    logic                  w_req_fire;
    logic                  w_resp_valid;
    logic                  w_resp_fire;
    vrf_read_req_t         w_req;
    vrf_read_tag_t         w_req_tag;
    logic [CW-1:0]         w_fifo_count;
    logic [DATA_WIDTH-1:0] w_head_data;
    vrf_read_tag_t         w_head_tag;

    logic [READ_LATENCY-1:0] r_vld_pipe;
    vrf_read_tag_t           r_tag_pipe [READ_LATENCY];

    assign w_req = '{vs: rd.req_bits_vs, readSource: rd.req_bits_readSource,
                     offset: rd.req_bits_offset,
                     instructionIndex: rd.req_bits_instructionIndex};
    assign w_req_tag = '{readSource: w_req.readSource,
                         instructionIndex: w_req.instructionIndex};

    // One credit per FIFO slot, taken at issue and returned at drain, so an issued read always has a home.
    assign w_req_ready  = (r_credit != '0);
    assign w_req_fire   = rd.req_valid & w_req_ready;
    assign w_resp_valid = (w_fifo_count != '0);
    assign w_resp_fire  = w_resp_valid & rd.resp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_credit <= CW'(RESP_DEPTH);
        end else begin
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   r_credit <= r_credit + 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (!(w_req_fire && !w_resp_fire && r_credit == '0));
            assert (!(w_resp_fire && !w_req_fire && r_credit == CW'(RESP_DEPTH)));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_req_fire;
            for (int i = 1; i < READ_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    // Tags need no reset; the valid bits alone decide whether a returning word is captured.
    always_ff @(posedge clock) begin
        r_tag_pipe[0] <= w_req_tag;
        for (int i = 1; i < READ_LATENCY; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
    end

    vrf_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH),
        .T_TAG      (vrf_read_tag_t)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (r_vld_pipe[READ_LATENCY-1]),
        .i_push_data (sram_rdata),
        .i_push_tag  (r_tag_pipe[READ_LATENCY-1]),
        .i_pop       (w_resp_fire),
        .o_count     (w_fifo_count),
        .o_head_data (w_head_data),
        .o_head_tag  (w_head_tag)
    );

    assign rd.req_ready                  = w_req_ready;
    assign rd.resp_valid                 = w_resp_valid;
    assign rd.resp_bits_data             = w_head_data;
    assign rd.resp_bits_readSource       = w_head_tag.readSource;
    assign rd.resp_bits_instructionIndex = w_head_tag.instructionIndex;
    assign sram_ren                      = w_req_fire;
    assign sram_addr                     = vrf_addr(w_req);
    assign idle                          = (r_credit == CW'(RESP_DEPTH));

`ifdef VRF_READ_RESPONDER_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_reads;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_reads <= '0;
        end else begin
            if (rd.req_valid && !w_req_ready && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
            if (w_req_fire && r_perf_reads != '1)                   r_perf_reads <= r_perf_reads + 1'b1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_reads        = r_perf_reads;
`endif
endmodule

// File: tb/tb_vrf_read_responder.sv
// Randomized directed bench for vrf_read_responder against a queue-based transaction model.
module tb_vrf_read_responder;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset;
    logic          sram_ren;
    logic [10:0]   sram_addr;
    logic [DW-1:0] sram_rdata;
    logic          idle;
`ifdef VRF_READ_RESPONDER_PERF_EN
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_reads;
`endif

    vrf_read_responder_if #(.DATA_WIDTH(DW)) rd();

    vrf_read_responder #(
        .DATA_WIDTH   (DW),
        .READ_LATENCY (LAT),
        .RESP_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rd         (rd),
        .sram_ren   (sram_ren),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .idle       (idle)
`ifdef VRF_READ_RESPONDER_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_reads        (perf_reads)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mem_f(input logic [10:0] a);
        return 32'h5EED_0000 ^ ({21'd0, a} * 32'h0001_0003);
    endfunction

    // SRAM model: fixed-latency read, random junk on cycles with no valid read.
    bit [LAT-1:0] sp_v;
    bit [10:0]    sp_addr [LAT];
    logic [DW-1:0] junk;
    always @(posedge clock) begin
        sp_v[0]    <= sram_ren;
        sp_addr[0] <= sram_addr;
        for (int i = 1; i < LAT; i++) begin
            sp_v[i]    <= sp_v[i-1];
            sp_addr[i] <= sp_addr[i-1];
        end
        junk <= $urandom;
    end
    assign sram_rdata = sp_v[LAT-1] ? mem_f(sp_addr[LAT-1]) : junk;

    // Reference model: every accepted request not yet drained, with its acceptance cycle.
    int            q_cyc  [$];
    logic [DW-1:0] q_data [$];
    logic [1:0]    q_rs   [$];
    logic [2:0]    q_ii   [$];
    int            cyc;
    int            m_stall;
    int            m_reads;
    int            n_cmp;
    int            n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_cyc.delete(); q_data.delete(); q_rs.delete(); q_ii.delete();
        m_stall = 0;
        m_reads = 0;
    endtask

    task automatic step(input bit v, input logic [4:0] vs, input logic [1:0] rs,
                        input logic [5:0] off, input logic [2:0] ii, input bit rr);
        bit          e_rdy, e_val;
        logic [10:0] a;
        a = 11'(vs * 64 + off);
        rd.req_valid = v; rd.req_bits_vs = vs; rd.req_bits_readSource = rs;
        rd.req_bits_offset = off; rd.req_bits_instructionIndex = ii; rd.resp_ready = rr;
        @(negedge clock);
        e_rdy = (q_cyc.size() < DEPTH);
        e_val = (q_cyc.size() > 0) && (cyc >= q_cyc[0] + LAT + 1);
        chk("req_ready", rd.req_ready, e_rdy);
        chk("resp_valid", rd.resp_valid, e_val);
        chk("idle", idle, q_cyc.size() == 0);
        chk("sram_ren", sram_ren, v && e_rdy);
        if (v && e_rdy) chk("sram_addr", sram_addr, a);
        if (e_val) begin
            chk("resp_data", rd.resp_bits_data, q_data[0]);
            chk("resp_rs", rd.resp_bits_readSource, q_rs[0]);
            chk("resp_ii", rd.resp_bits_instructionIndex, q_ii[0]);
        end
`ifdef VRF_READ_RESPONDER_PERF_EN
        chk("perf_stall", perf_stall_cycles, m_stall);
        chk("perf_reads", perf_reads, m_reads);
`endif
        @(posedge clock);
        if (e_val && rr) begin
            void'(q_cyc.pop_front()); void'(q_data.pop_front());
            void'(q_rs.pop_front());  void'(q_ii.pop_front());
        end
        if (v && e_rdy) begin
            q_cyc.push_back(cyc); q_data.push_back(mem_f(a));
            q_rs.push_back(rs);   q_ii.push_back(ii);
            m_reads++;
        end
        if (v && !e_rdy) m_stall++;
        cyc++;
        #1;
    endtask

    task automatic rstep(input bit v, input bit rr);
        step(v, 5'($urandom), 2'($urandom), 6'($urandom), 3'($urandom), rr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rd.req_valid = 1'b0;
        #2;
        chk("rst_req_ready", rd.req_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_resp_valid", rd.resp_valid, 1'b0);
        chk("rst_sram_ren", sram_ren, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        model_clear();
        reset = 1'b1;
        rd.req_valid = 1'b0; rd.resp_ready = 1'b0;
        rd.req_bits_vs = '0; rd.req_bits_readSource = '0;
        rd.req_bits_offset = '0; rd.req_bits_instructionIndex = '0;
        #3;
        chk("init_req_ready", rd.req_ready, 1'b1);
        chk("init_idle", idle, 1'b1);
        chk("init_resp_valid", rd.resp_valid, 1'b0);
        chk("init_sram_ren", sram_ren, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // single read: address {3,10} = 0x0CA, response three cycles later
        step(1'b1, 5'd3, 2'd2, 6'd10, 3'd5, 1'b1);
        for (int i = 0; i < 5; i++) rstep(1'b0, 1'b1);

        // back-to-back
        for (int i = 0; i < 8; i++) rstep(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) rstep(1'b0, 1'b1);

        // backpressure, then drain
        for (int i = 0; i < 6; i++) rstep(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) rstep(1'b0, 1'b1);

        // full FIFO with zero credit, then simultaneous push/pop
        for (int i = 0; i < 8;  i++) rstep(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) rstep(1'b1, 1'b1);
        for (int i = 0; i < 8;  i++) rstep(1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) rstep(1'($urandom), ($urandom % 4) != 0);
        for (int i = 0; i < 10;  i++) rstep(1'b0, 1'b1);

        // reset with two reads in flight; their late data must be dropped
        rstep(1'b1, 1'b1);
        rstep(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) rstep(1'b0, 1'b1);

        // four reads then three stalled cycles
        for (int i = 0; i < 7; i++) rstep(1'b1, 1'b0);
`ifdef VRF_READ_RESPONDER_PERF_EN
        chk("perf_stall_3", perf_stall_cycles, 32'd3);
        chk("perf_reads_4", perf_reads, 32'd4);
`endif
        for (int i = 0; i < 8; i++) rstep(1'b0, 1'b1);
        step(1'b1, 5'd31, 2'd1, 6'd63, 3'd7, 1'b1);
        for (int i = 0; i < 5; i++) rstep(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
